// File: rtl/user_obi_rr_arbiter.sv
// user_obi_rr_arbiter: round-robin arbiter that shares one OBI subordinate
// port between NumMgr managers. Granted manager indices are kept in an
// in-order ID FIFO so that each response is returned to the manager that
// issued it. Optional per-manager stall counters are enabled with the macro
// USER_OBI_ARB_STALL_CNT_EN. Without it, stall_cnt_o is tied to zero.
module user_obi_rr_arbiter #(
  parameter int unsigned NumMgr    = 2,
  parameter int unsigned MaxTrans  = 4,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumMgr-1:0]             mgr_req_i,
  output logic [NumMgr-1:0]             mgr_gnt_o,
  input  logic [NumMgr*AddrWidth-1:0]   mgr_addr_i,
  input  logic [NumMgr-1:0]             mgr_we_i,
  input  logic [NumMgr*DataWidth/8-1:0] mgr_be_i,
  input  logic [NumMgr*DataWidth-1:0]   mgr_wdata_i,
  output logic [NumMgr-1:0]             mgr_rvalid_o,
  output logic [DataWidth-1:0]          mgr_rdata_o,
  output logic                          mgr_err_o,
  output logic                          sbr_req_o,
  input  logic                          sbr_gnt_i,
  output logic [AddrWidth-1:0]          sbr_addr_o,
  output logic                          sbr_we_o,
  output logic [DataWidth/8-1:0]        sbr_be_o,
  output logic [DataWidth-1:0]          sbr_wdata_o,
  input  logic                          sbr_rvalid_i,
  input  logic [DataWidth-1:0]          sbr_rdata_i,
  input  logic                          sbr_err_i,
  output logic                          spurious_o,
  output logic [NumMgr*16-1:0]          stall_cnt_o
);

  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned BeW  = DataWidth / 8;

  logic [IdxW-1:0] rr_ptr;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx;
  logic [IdxW-1:0] winner;
  logic [IdxW-1:0] fifo_mem [MaxTrans];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [CntW-1:0] cnt;
  logic            spurious_q;
  logic            any_req;
  logic            full;
  logic            push;
  logic            pop;
  logic [IdxW-1:0] head;
  logic            found;
  int unsigned     scan_idx;

  // Winner selection: a stalled request keeps its slot, otherwise scan from rr_ptr.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    if (lock_q && mgr_req_i[lock_idx]) begin
      winner = lock_idx;
    end else begin
      for (int unsigned k = 0; k < NumMgr; k++) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NumMgr) scan_idx = scan_idx - NumMgr;
        if (!found && mgr_req_i[IdxW'(scan_idx)]) begin
          winner = IdxW'(scan_idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign any_req   = |mgr_req_i;
  assign full      = (cnt == CntW'(MaxTrans));
  assign sbr_req_o = any_req && !full;
  assign push      = sbr_req_o && sbr_gnt_i;
  assign pop       = sbr_rvalid_i && (cnt != '0);
  assign head      = fifo_mem[rd_ptr];

  // With no requests the winner defaults to 0, so manager 0 drives the fields.
  assign sbr_addr_o  = mgr_addr_i[winner*AddrWidth +: AddrWidth];
  assign sbr_we_o    = mgr_we_i[winner];
  assign sbr_be_o    = mgr_be_i[winner*BeW +: BeW];
  assign sbr_wdata_o = mgr_wdata_i[winner*DataWidth +: DataWidth];

  assign mgr_rdata_o = sbr_rdata_i;
  assign mgr_err_o   = sbr_err_i;
  assign spurious_o  = spurious_q;

  // Grant only the winner, and only on an actual subordinate handshake.
  always_comb begin
    mgr_gnt_o = '0;
    if (push) mgr_gnt_o[winner] = 1'b1;
  end

  // Route a response to the manager at the FIFO head (pre-push value).
  always_comb begin
    mgr_rvalid_o = '0;
    if (pop) mgr_rvalid_o[head] = 1'b1;
  end

  // Control state: round-robin pointer, lock, FIFO pointers, occupancy, spurious flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr     <= '0;
      lock_q     <= 1'b0;
      lock_idx   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      spurious_q <= 1'b0;
    end else begin
      lock_q <= sbr_req_o && !sbr_gnt_i;
      if (sbr_req_o && !sbr_gnt_i) lock_idx <= winner;
      if (push) begin
        rr_ptr <= (winner == IdxW'(NumMgr - 1)) ? '0 : winner + 1'b1;
        wr_ptr <= (wr_ptr == PtrW'(MaxTrans - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= (rd_ptr == PtrW'(MaxTrans - 1)) ? '0 : rd_ptr + 1'b1;
      if (push && !pop) cnt <= cnt + 1'b1;
      else if (!push && pop) cnt <= cnt - 1'b1;
      if (sbr_rvalid_i && (cnt == '0)) spurious_q <= 1'b1;
    end
  end

  // ID FIFO storage holds data only, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= winner;
  end

`ifdef USER_OBI_ARB_STALL_CNT_EN
  for (genvar i = 0; i < NumMgr; i++) begin : g_stall
    logic [15:0] stall_q;
    // Count cycles a manager requests without a grant, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        stall_q <= '0;
      end else if (mgr_req_i[i] && !mgr_gnt_o[i] && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
    end
    assign stall_cnt_o[i*16 +: 16] = stall_q;
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_user_obi_rr_arbiter.sv
// Self-checking bench for user_obi_rr_arbiter (NumMgr=2, MaxTrans=4).
// A directed vector table covers alternation, lock, full and response
// routing; hand-written sequences cover stall counters, spurious responses
// and reset.
module tb_user_obi_rr_arbiter;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] W0 = 32'hD0D0_0000;
  localparam logic [31:0] W1 = 32'hD1D1_1111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mgr_req = '0;
  logic [1:0]  mgr_gnt;
  logic [63:0] mgr_addr;
  logic [1:0]  mgr_we;
  logic [7:0]  mgr_be;
  logic [63:0] mgr_wdata;
  logic [1:0]  mgr_rvalid;
  logic [31:0] mgr_rdata;
  logic        mgr_err;
  logic        sbr_req;
  logic        sbr_gnt = 1'b0;
  logic [31:0] sbr_addr;
  logic        sbr_we;
  logic [3:0]  sbr_be;
  logic [31:0] sbr_wdata;
  logic        sbr_rvalid = 1'b0;
  logic [31:0] sbr_rdata = '0;
  logic        sbr_err = 1'b0;
  logic        spurious;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  assign mgr_addr  = {A1, A0};
  assign mgr_we    = 2'b10;
  assign mgr_be    = 8'h3F;
  assign mgr_wdata = {W1, W0};

  user_obi_rr_arbiter #(
    .NumMgr(2), .MaxTrans(4), .AddrWidth(32), .DataWidth(32)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .mgr_req_i(mgr_req), .mgr_gnt_o(mgr_gnt), .mgr_addr_i(mgr_addr),
    .mgr_we_i(mgr_we), .mgr_be_i(mgr_be), .mgr_wdata_i(mgr_wdata),
    .mgr_rvalid_o(mgr_rvalid), .mgr_rdata_o(mgr_rdata), .mgr_err_o(mgr_err),
    .sbr_req_o(sbr_req), .sbr_gnt_i(sbr_gnt), .sbr_addr_o(sbr_addr),
    .sbr_we_o(sbr_we), .sbr_be_o(sbr_be), .sbr_wdata_o(sbr_wdata),
    .sbr_rvalid_i(sbr_rvalid), .sbr_rdata_i(sbr_rdata), .sbr_err_i(sbr_err),
    .spurious_o(spurious), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  e_gnt;
    logic [1:0]  e_rv;
    logic        e_req;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] req, logic gnt, logic rv, logic [31:0] rdata,
                              logic err, logic [1:0] e_gnt, logic [1:0] e_rv,
                              logic e_req, logic [31:0] e_addr);
    vec_t v;
    v.req = req; v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.err = err;
    v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_req = e_req; v.e_addr = e_addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic err);
    mgr_req = req; sbr_gnt = gnt; sbr_rvalid = rv; sbr_rdata = rdata; sbr_err = err;
  endtask

  logic [15:0] exp_stall1;

  initial begin
    // Alternation with a response each following cycle
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b01, 2'b00, 1, A0));
    tbl.push_back(mk(2'b11, 1, 1, 32'hA1, 0, 2'b10, 2'b01, 1, A1));
    tbl.push_back(mk(2'b11, 1, 1, 32'hA2, 1, 2'b01, 2'b10, 1, A0));
    tbl.push_back(mk(2'b11, 1, 1, 32'hA3, 0, 2'b10, 2'b01, 1, A1));
    tbl.push_back(mk(2'b00, 0, 1, 32'hA4, 0, 2'b00, 2'b10, 0, A0));
    // Subordinate stalls M1 for 3 cycles, M0 joins on the second
    tbl.push_back(mk(2'b10, 0, 0, 32'h0,  0, 2'b00, 2'b00, 1, A1));
    tbl.push_back(mk(2'b11, 0, 0, 32'h0,  0, 2'b00, 2'b00, 1, A1));
    tbl.push_back(mk(2'b11, 0, 0, 32'h0,  0, 2'b00, 2'b00, 1, A1));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,  0, 2'b01, 2'b00, 1, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hB0, 0, 2'b00, 2'b10, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hB1, 0, 2'b00, 2'b01, 0, A0));
    // Fill to MaxTrans, blocked while full, one pop reopens a cycle later
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b01, 2'b00, 1, A0));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b01, 2'b00, 1, A0));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b00, 2'b00, 0, A1));
    tbl.push_back(mk(2'b11, 1, 1, 32'hC0, 0, 2'b00, 2'b10, 0, A1));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(2'b11, 1, 0, 32'h0,  0, 2'b00, 2'b00, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hD0, 0, 2'b00, 2'b01, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hD1, 0, 2'b00, 2'b10, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hD2, 0, 2'b00, 2'b01, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hD3, 0, 2'b00, 2'b10, 0, A0));
    // Issue M0,M1,M1 then three responses
    tbl.push_back(mk(2'b01, 1, 0, 32'h0,  0, 2'b01, 2'b00, 1, A0));
    tbl.push_back(mk(2'b10, 1, 0, 32'h0,  0, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(2'b10, 1, 0, 32'h0,  0, 2'b10, 2'b00, 1, A1));
    tbl.push_back(mk(2'b00, 0, 1, 32'hA,  0, 2'b00, 2'b01, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hB,  0, 2'b00, 2'b10, 0, A0));
    tbl.push_back(mk(2'b00, 0, 1, 32'hC,  0, 2'b00, 2'b10, 0, A0));

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_gnt", 64'(mgr_gnt), 64'h0);
    check("rst_rvalid", 64'(mgr_rvalid), 64'h0);
    check("rst_sbr_req", 64'(sbr_req), 64'h0);
    check("rst_spurious", 64'(spurious), 64'h0);
    check("rst_stall", 64'(stall_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].req, tbl[i].gnt, tbl[i].rv, tbl[i].rdata, tbl[i].err);
      #1;
      check($sformatf("v%0d_gnt", i), 64'(mgr_gnt), 64'(tbl[i].e_gnt));
      check($sformatf("v%0d_rvalid", i), 64'(mgr_rvalid), 64'(tbl[i].e_rv));
      check($sformatf("v%0d_sbr_req", i), 64'(sbr_req), 64'(tbl[i].e_req));
      check($sformatf("v%0d_addr", i), 64'(sbr_addr), 64'(tbl[i].e_addr));
      check($sformatf("v%0d_wdata", i), 64'(sbr_wdata),
            64'((tbl[i].e_addr == A1) ? W1 : W0));
      check($sformatf("v%0d_we", i), 64'(sbr_we), 64'(tbl[i].e_addr == A1));
      check($sformatf("v%0d_spurious", i), 64'(spurious), 64'h0);
      if (tbl[i].rv) begin
        check($sformatf("v%0d_rdata", i), 64'(mgr_rdata), 64'(tbl[i].rdata));
        check($sformatf("v%0d_err", i), 64'(mgr_err), 64'(tbl[i].err));
      end
    end

    // Fresh reset before the stall-counter sequence
    @(negedge clk);
    drive(2'b00, 0, 0, 32'h0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // M1 requests while the subordinate withholds gnt for 5 cycles
    @(negedge clk);
    drive(2'b10, 0, 0, 32'h0, 0);
    repeat (5) @(negedge clk);
`ifdef USER_OBI_ARB_STALL_CNT_EN
    exp_stall1 = 16'd5;
`else
    exp_stall1 = 16'd0;
`endif
    #1;
    check("stall_m1", 64'(stall_cnt[31:16]), 64'(exp_stall1));
    check("stall_m0", 64'(stall_cnt[15:0]), 64'h0);

    // Manager drops req while locked: nothing pushed, so a response is spurious
    drive(2'b00, 0, 0, 32'h0, 0);
    @(negedge clk);
    drive(2'b00, 0, 1, 32'h55, 0);
    #1;
    check("drop_rvalid", 64'(mgr_rvalid), 64'h0);
    check("drop_spurious_pre", 64'(spurious), 64'h0);
    @(negedge clk);
    drive(2'b00, 0, 0, 32'h0, 0);
    #1;
    check("drop_spurious_set", 64'(spurious), 64'h1);
    repeat (3) @(negedge clk);
    #1;
    check("spurious_sticky", 64'(spurious), 64'h1);
    rst_n = 1'b0;
    #1;
    check("spurious_rst", 64'(spurious), 64'h0);
    check("stall_rst", 64'(stall_cnt), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // rvalid with no request after reset
    @(negedge clk);
    drive(2'b00, 0, 1, 32'h77, 0);
    #1;
    check("spur2_rvalid", 64'(mgr_rvalid), 64'h0);
    @(negedge clk);
    drive(2'b00, 0, 0, 32'h0, 0);
    #1;
    check("spur2_set", 64'(spurious), 64'h1);
    check("spur2_sbr_req", 64'(sbr_req), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
